// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the instruction
// fetch unit and the load/store unit. Round-robin on ties, one transaction
// in flight, responses registered and returned only to the owning requester.
module mem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch port
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_resp_valid,
  output logic [31:0]   if_rdata,
  // load/store port
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [7:0]    ls_wmask,
  output logic          ls_resp_valid,
  output logic [DW-1:0] ls_rdata,
  // physical memory port
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  state_t state;
  owner_t owner;
  owner_t last_grant;

  logic grant_if;
  logic grant_ls;

  // Grant decision: only in IDLE; on a tie the requester not served last wins.
  // The ready is a same-cycle decode so the requester sees the handshake in
  // the grant cycle itself.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == IDLE && !rst) begin
      if (ls_req_valid && (!if_req_valid || last_grant == OWN_IF)) begin
        grant_ls = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // Transaction FSM: latch the granted request, present it to memory, then
  // route the registered response back to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      last_grant    <= OWN_IF;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      if_resp_valid <= 1'b0;
      if_rdata      <= '0;
      ls_resp_valid <= 1'b0;
      ls_rdata      <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            owner         <= OWN_LS;
            last_grant    <= OWN_LS;
            mem_we        <= ls_we;
            mem_addr      <= ls_addr;
            mem_wdata     <= ls_wdata;
            mem_wmask     <= ls_wmask;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end else if (grant_if) begin
            owner         <= OWN_IF;
            last_grant    <= OWN_IF;
            mem_we        <= 1'b0;
            mem_addr      <= if_addr;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // a response arriving together with ready is not consumed here
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state <= IDLE;
            if (owner == OWN_LS) begin
              ls_resp_valid <= 1'b1;
              ls_rdata      <= mem_we ? '0 : mem_rdata;
            end else begin
              if_resp_valid <= 1'b1;
              if_rdata      <= mem_addr[2] ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and a delay-programmable memory,
// checked cycle by cycle against a transaction-level timing/arbitration model.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    wmask;
  } ls_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [AW-1:0] if_addr = '0;
  logic          if_resp_valid;
  logic [31:0]   if_rdata;
  logic          ls_req_valid = 1'b0;
  logic          ls_req_ready;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [7:0]    ls_wmask = '0;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls
  int          rdly = 0;
  int          sdly = 0;
  bit          spur_en = 1'b0;
  bit          force_en = 1'b0;
  logic [63:0] force_val = '0;

  // reference model state
  bit          m_last = 1'b0;   // 0 = IFU served last, 1 = LSU
  logic [AW-1:0] if_q[$];
  ls_t         ls_q[$];
  bit          grant_log[$];

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memf(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[63:32] ^ a[31:0]};
  endfunction

  // Memory: after seeing a request waits rdly cycles before ready, then sdly
  // further cycles before a one-cycle response. Optional spurious responses.
  int mp = 0;
  int mcnt = 0;
  int cur_r = 0;
  int cur_s = 0;
  always @(posedge clk) begin
    #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = {$urandom, $urandom};
    if (mp == 0 && mem_req_valid) begin
      mp = 1; mcnt = 0; cur_r = rdly; cur_s = sdly;
    end
    if (mp == 1) begin
      if (mcnt == cur_r) begin
        mem_req_ready = 1'b1;
        if (spur_en && $urandom_range(1, 0) == 1) mem_resp_valid = 1'b1;
        mp = 2; mcnt = 0;
      end else begin
        if (spur_en && $urandom_range(2, 0) == 0) mem_resp_valid = 1'b1;
        mcnt++;
      end
    end else if (mp == 2) begin
      if (mcnt == cur_s) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = force_en ? force_val : memf(mem_addr);
        mp = 0; mcnt = 0;
      end else begin
        mcnt++;
      end
    end else if (spur_en && $urandom_range(2, 0) == 0) begin
      mem_resp_valid = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the queued requests and checks every cycle against the model:
  // grant when no transaction is outstanding (or its response lands this
  // cycle), tie goes to the requester not served last, response arrives
  // 3 + ready delay + response delay cycles after the grant.
  task automatic run_traffic(input int rmin, input int rmax, input int smin, input int smax,
                             input bit gaps, input int budget);
    int cyc, g, rd, sd, rc;
    bit busy, own, ip, lp, gi, gl, e_if, e_ls, e_mrv;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [7:0]    em;
    logic [63:0]   dd, exp_d;
    logic [AW-1:0] a;
    ls_t           cur;
    cyc = 0; g = 0; rd = 0; sd = 0; rc = 0;
    busy = 0; own = 0; ip = 0; lp = 0;
    ew = 0; ea = '0; ewd = '0; em = '0; exp_d = '0;
    grant_log.delete();
    while ((if_q.size() > 0 || ls_q.size() > 0 || busy) && cyc < budget) begin
      step();
      if (!ip && if_q.size() > 0) ip = !gaps || ($urandom_range(3, 0) != 0);
      if (!lp && ls_q.size() > 0) lp = !gaps || ($urandom_range(3, 0) != 0);
      if_req_valid = ip;
      if_addr      = ip ? if_q[0] : {$urandom, $urandom};
      ls_req_valid = lp;
      if (lp) begin
        ls_we = ls_q[0].we; ls_addr = ls_q[0].addr;
        ls_wdata = ls_q[0].wdata; ls_wmask = ls_q[0].wmask;
      end else begin
        ls_we = 1'($urandom); ls_addr = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom}; ls_wmask = 8'($urandom);
      end
      #1;
      e_if = busy && rc == cyc && !own;
      e_ls = busy && rc == cyc && own;
      n_checks++;
      if (if_resp_valid !== e_if) begin
        n_fail++; $display("FAIL if_resp_valid cyc %0d: got %b expected %b", cyc, if_resp_valid, e_if);
      end
      n_checks++;
      if (ls_resp_valid !== e_ls) begin
        n_fail++; $display("FAIL ls_resp_valid cyc %0d: got %b expected %b", cyc, ls_resp_valid, e_ls);
      end
      if (e_if) begin
        n_checks++;
        if (if_rdata !== exp_d[31:0]) begin
          n_fail++; $display("FAIL if_rdata cyc %0d: got %h expected %h", cyc, if_rdata, exp_d[31:0]);
        end
      end
      if (e_ls) begin
        n_checks++;
        if (ls_rdata !== exp_d) begin
          n_fail++; $display("FAIL ls_rdata cyc %0d: got %h expected %h", cyc, ls_rdata, exp_d);
        end
      end
      e_mrv = busy && cyc >= g + 1 && cyc <= g + 1 + rd;
      n_checks++;
      if (mem_req_valid !== e_mrv) begin
        n_fail++; $display("FAIL mem_req_valid cyc %0d: got %b expected %b", cyc, mem_req_valid, e_mrv);
      end
      if (e_mrv) begin
        n_checks++;
        if ({mem_we, mem_addr, mem_wmask} !== {ew, ea, em}) begin
          n_fail++; $display("FAIL mem_fields cyc %0d: got we=%b addr=%h mask=%h expected we=%b addr=%h mask=%h",
                             cyc, mem_we, mem_addr, mem_wmask, ew, ea, em);
        end
        if (own) begin
          n_checks++;
          if (mem_wdata !== ewd) begin
            n_fail++; $display("FAIL mem_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, ewd);
          end
        end
      end
      if (busy && rc == cyc) busy = 0;
      gi = 0; gl = 0;
      if (!busy) begin
        if (lp && (!ip || !m_last)) gl = 1;
        else if (ip) gi = 1;
      end
      n_checks++;
      if ({if_req_ready, ls_req_ready} !== {gi, gl}) begin
        n_fail++; $display("FAIL req_ready cyc %0d: got if=%b ls=%b expected if=%b ls=%b",
                           cyc, if_req_ready, ls_req_ready, gi, gl);
      end
      if (gi || gl) begin
        busy = 1; g = cyc;
        rd = $urandom_range(rmax, rmin); sd = $urandom_range(smax, smin);
        rdly = rd; sdly = sd;
        rc = cyc + 3 + rd + sd;
        own = gl; m_last = gl;
        grant_log.push_back(gl);
        if (gl) begin
          cur = ls_q.pop_front(); lp = 0;
          dd = force_en ? force_val : memf(cur.addr);
          exp_d = cur.we ? 64'h0 : dd;
          ew = cur.we; ea = cur.addr; ewd = cur.wdata; em = cur.wmask;
        end else begin
          a = if_q.pop_front(); ip = 0;
          dd = force_en ? force_val : memf(a);
          exp_d = {32'h0, a[2] ? dd[63:32] : dd[31:0]};
          ew = 1'b0; ea = a; ewd = '0; em = 8'h00;
        end
      end
      cyc++;
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    n_checks++;
    if (busy || if_q.size() > 0 || ls_q.size() > 0) begin
      n_fail++; $display("FAIL traffic_timeout: got %0d cycles used, expected completion within %0d", cyc, budget);
      if_q.delete(); ls_q.delete();
    end
  endtask

  task automatic push_ls(input logic we, input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] wm);
    ls_t t;
    t.we = we; t.addr = addr; t.wdata = wd; t.wmask = wm;
    ls_q.push_back(t);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, mem_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid, mem_we});
    end
    n_checks++;
    if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin
      n_fail++; $display("FAIL reset_data: got if_rdata=%h ls_rdata=%h addr=%h wdata=%h mask=%h expected all 0",
                         if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask);
    end
    step();
    rst = 1'b0;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic test_contention();
    bit exp_order[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    force_en = 1'b0;
    if_q.push_back(64'h8000_0100);
    if_q.push_back(64'h8000_0104);
    push_ls(1'b0, 64'h8000_2008, 64'h0, 8'h00);
    push_ls(1'b1, 64'h8000_2010, 64'h0123_4567_89AB_CDEF, 8'hF0);
    run_traffic(0, 0, 0, 0, 1'b0, 100);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_log.size() <= i || grant_log[i] !== exp_order[i]) begin
        n_fail++; $display("FAIL contention_order[%0d]: got %0d grants (owner %b) expected owner %b",
                           i, grant_log.size(), (grant_log.size() > i) ? grant_log[i] : 1'bx, exp_order[i]);
      end
    end
  endtask

  task automatic test_single_fetch();
    force_en = 1'b1;
    force_val = 64'h1122_3344_5566_7788;
    if_q.push_back(64'h8000_0004);
    if_q.push_back(64'h8000_0000);
    run_traffic(0, 0, 0, 0, 1'b0, 50);
  endtask

  task automatic test_load();
    force_en = 1'b1;
    force_val = 64'hDEAD_BEEF_CAFE_F00D;
    push_ls(1'b0, 64'h8000_1000, 64'h0, 8'h00);
    run_traffic(0, 0, 0, 0, 1'b0, 50);
  endtask

  task automatic test_store();
    force_en = 1'b0;
    push_ls(1'b1, 64'h8000_1008, 64'h0000_0000_0000_00AB, 8'h01);
    run_traffic(3, 3, 1, 1, 1'b0, 50);
  endtask

  task automatic test_back_pressure();
    force_en = 1'b0;
    if_q.push_back(64'h8000_0040);
    push_ls(1'b0, 64'h8000_3000, 64'h0, 8'h00);
    run_traffic(5, 5, 4, 4, 1'b0, 100);
  endtask

  task automatic test_reset_mid_wait();
    force_en = 1'b0;
    rdly = 0;
    sdly = 6;
    step();
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_2000;
    ls_wdata = '0; ls_wmask = '0;
    #1;
    n_checks++;
    if (ls_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midwait_grant: got %b expected 1", ls_req_ready);
    end
    step();
    ls_req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_req_valid, if_resp_valid, ls_resp_valid, mem_we, mem_addr, ls_rdata} !== '0) begin
      n_fail++; $display("FAIL midwait_reset_state: got mem_req_valid=%b resp=%b%b addr=%h ls_rdata=%h expected all 0",
                         mem_req_valid, if_resp_valid, ls_resp_valid, mem_addr, ls_rdata);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      n_checks++;
      if ({if_resp_valid, ls_resp_valid, mem_req_valid} !== 3'b000) begin
        n_fail++; $display("FAIL midwait_no_resp[%0d]: got if=%b ls=%b mreq=%b expected 000",
                           i, if_resp_valid, ls_resp_valid, mem_req_valid);
      end
    end
    m_last = 1'b0;
    if_q.push_back(64'h8000_0080);
    push_ls(1'b0, 64'h8000_4000, 64'h0, 8'h00);
    run_traffic(0, 1, 0, 1, 1'b0, 100);
    n_checks++;
    if (grant_log.size() == 0 || grant_log[0] !== 1'b1) begin
      n_fail++; $display("FAIL midwait_tie_after_reset: got %0d grants first=%b expected first=1 (LSU)",
                         grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 1'bx);
    end
  endtask

  task automatic test_random();
    force_en = 1'b0;
    spur_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if_q.push_back({$urandom, $urandom} & ~64'h3);
      push_ls(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
    end
    run_traffic(0, 3, 0, 3, 1'b1, 2000);
    spur_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_fetch();
    test_load();
    test_store();
    test_back_pressure();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter between the instruction fetch unit (IFU) and the load/store unit (LSU) of the NPC core. The block owns the single physical memory port (the DPI-backed main memory), grants it to one requester at a time with round-robin fairness, and keeps exactly one transaction outstanding. Responses are registered and routed back to the requester that owns the transaction.

## Interface
Parameters:
- AW, 64, address width (all address ports)
- DW, 64, memory data width; IFU data is DW/2 = 32

Ports:
- clk  in  1  core clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IFU fetch request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  AW  fetch address (4-byte aligned)
- if_resp_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_wmask  in  8  byte-enable mask for stores
- ls_resp_valid  out  1  one-cycle pulse: load data / store ack
- ls_rdata  out  DW  load data; 0 on store ack
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepted request
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/8  latched request fields
- mem_resp_valid  in  1  memory response valid
- mem_rdata  in  DW  memory read data (aligned doubleword)

## Operation
- FSM states: IDLE, REQ, WAIT. Reset -> IDLE.
- IDLE: if any req_valid, grant one, pulse its req_ready for 1 cycle, latch owner, we, addr, wdata, wmask (IFU: we=0, wmask=0) -> REQ. No request: stay.
- Arbitration: only one valid -> grant it. Both valid -> grant the one NOT granted last (last_grant register; reset value = IFU, so LSU wins the first tie).
- REQ: mem_req_valid=1, fields held stable; on mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid, register response -> IDLE. Next cycle owner's resp_valid=1 for exactly one cycle.
- IFU data: if_rdata = latched if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- LSU data: load -> ls_rdata = mem_rdata; store -> ls_rdata = 0 (ack only).
- Non-owner resp_valid stays 0; mem_resp_valid outside WAIT ignored.
- Requesters hold valid and fields until req_ready; arbiter samples fields only in the grant cycle.

## Timing
- Reset values: all *_ready, *_resp_valid, mem_req_valid = 0; if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask, mem_we = 0; last_grant = IFU.
- Grant at cycle T (IDLE) -> mem_req_valid at T+1. With mem_req_ready at T+1 and mem_resp_valid at T+2 -> resp_valid at T+3 (minimum latency 3).
- resp_valid cycle coincides with IDLE: a new grant may occur in the same cycle, so peak throughput is one transaction per 3 cycles.
- Memory stalls (ready/resp held low) extend REQ/WAIT indefinitely; no timeout.
- rst asserted in any state: next cycle IDLE, all outputs at reset values, in-flight transaction dropped, no resp_valid delivered. last_grant resets to IFU.
- mem_req_ready and mem_resp_valid both high in REQ: only the ready is consumed (-> WAIT); the response must come later.

## Test plan
- Single fetch: if_addr=0x80000004, memory returns 0x1122334455667788 -> if_req_ready at T, if_resp_valid at T+3, if_rdata=0x11223344; if_addr=0x80000000 returns 0x55667788.
- Load: ls_we=0, ls_addr=0x80001000, mem_rdata=0xDEADBEEFCAFEF00D -> ls_rdata=0xDEADBEEFCAFEF00D, one-cycle ls_resp_valid, if_resp_valid stays 0.
- Store: ls_we=1, ls_wdata=0xAB, ls_wmask=0x01 -> mem_we=1, mem_wmask=0x01, fields stable through REQ; ack with ls_rdata=0.
- Contention: both valid continuously for 4 transactions -> grant order LSU, IFU, LSU, IFU; each owner gets exactly its responses.
- Back-pressure: mem_req_ready low 5 cycles, mem_resp_valid delayed 4 more -> mem fields constant, no new grants, resp at ready+resp delay +1.
- Reset mid-WAIT: rst high 1 cycle while WAIT, later mem_resp_valid -> no resp_valid pulse, state IDLE, next tie grants LSU.
